// File: rtl/alu_pkg.sv
// Shared definitions for the power ALU datapath: default width and the
// state encoding used by the serial adder.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } adder_state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the serial adder, with the FSM state exposed
// for observation alongside the result.
interface serial_adder_if import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
);

    // start is taken only while busy=0 (IDLE or DONE); sub/a/b/cin are
    // captured on that same edge. done pulses for exactly one cycle with
    // sum/cout/ovf valid, and those outputs hold until the next done.
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    adder_state_t     state;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf, state
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf, state
    );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell used as the building block of ripple chains.
module full_adder (
    output logic s,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: consumes DIGIT bits per clock through a
// short full_adder ripple chain, delivering the result after WIDTH/DIGIT cycles.
module serial_adder import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DIGIT = 1
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    adder_state_t state_q, state_d;
    logic             load;
    logic             last;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, sum_q;
    logic             carry, cout_q, ovf_q;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] s;
    logic             chain_cout, msb_cin;
    logic [WIDTH+DIGIT-1:0] res_cat;

    // Each cell gets its own carry nets so the chain is not one self-feeding vector.
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
        logic ci, co;
        if (gi == 0) begin : g_first
            assign ci = carry;
        end else begin : g_next
            assign ci = g_fa[gi-1].co;
        end
        full_adder u_fa (
            .s   (s[gi]),
            .cout(co),
            .a   (a_sr[gi]),
            .b   (b_sr[gi]),
            .cin (ci)
        );
    end

    assign chain_cout = g_fa[DIGIT-1].co;
    assign msb_cin    = g_fa[DIGIT-1].ci;
    assign res_cat    = {s, res_sr};
    assign last       = (cnt == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                // The DONE cycle doubles as a capture cycle for back-to-back work.
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load) begin
            a_sr  <= bus.a;
            b_sr  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub | bus.cin;
            cnt   <= '0;
        end else if (state_q == RUN) begin
            a_sr   <= a_sr >> DIGIT;
            b_sr   <= b_sr >> DIGIT;
            res_sr <= res_cat[WIDTH+DIGIT-1:DIGIT];
            carry  <= chain_cout;
            cnt    <= cnt + CW'(1);
            // Outputs update only on the final digit, so partial sums never show.
            if (last) begin
                sum_q  <= res_cat[WIDTH+DIGIT-1:DIGIT];
                cout_q <= chain_cout;
                ovf_q  <= msb_cin ^ chain_cout;
            end
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
    assign bus.state = state_q;

endmodule
